// File: rtl/maj_pkg.sv
// Shared definitions for the sequential majority voter: state encodings and
// legal parameter bounds, plus a helper used for elaboration-time checking.
package maj_pkg;

  typedef enum logic [1:0] {
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int unsigned N_MIN  = 3;
  localparam int unsigned N_MAX  = 15;
  localparam int unsigned D_MIN  = 1;
  localparam int unsigned D_MAX  = 31;
  localparam int unsigned TH_MIN = 1;
  localparam int unsigned TH_MAX = 15;

  function automatic bit params_ok(input int unsigned n, input int unsigned d,
                                   input int unsigned th);
    return (n % 2 == 1) && (n >= N_MIN) && (n <= N_MAX) &&
           (d % 2 == 1) && (d >= D_MIN) && (d <= D_MAX) &&
           (th >= TH_MIN) && (th <= TH_MAX);
  endfunction

endpackage

// File: rtl/maj_vote_seq_popcnt.sv
// Combinational population count of a W-bit vector.
module popcnt #(
  parameter int unsigned W = 3
) (
  input  logic [W-1:0]         i_bits,
  output logic [$clog2(W+1)-1:0] o_count
);

  localparam int unsigned CW = $clog2(W+1);

  always_comb begin
    o_count = '0;
    for (int unsigned k = 0; k < W; k++) begin
      o_count = o_count + CW'(i_bits[k]);
    end
  end

endmodule

// File: rtl/maj_vote_seq.sv
// Spatial majority over N voter channels followed by a temporal majority over
// the last D spatial results, with per-channel sticky disagreement faults.
module maj_vote_seq
  import maj_pkg::*;
#(
  parameter int unsigned N        = 3,
  parameter int unsigned D        = 5,
  parameter int unsigned FAULT_TH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic [N-1:0]             din,
  output logic                     out_valid,
  output logic                     out,
  output logic                     spatial,
  output logic [$clog2(N+1)-1:0]   count,
  output logic [N-1:0]             fault,
  output logic [1:0]               state
);

  localparam int unsigned CW = $clog2(N+1);
  localparam int unsigned WW = $clog2(D+1);
  localparam int unsigned FW = $clog2(D+1);
  localparam int unsigned TW = $clog2(FAULT_TH+1);
  localparam logic [CW-1:0] NHALF = CW'(N/2);
  localparam logic [WW-1:0] DHALF = WW'(D/2);
  localparam logic [TW-1:0] TH    = TW'(FAULT_TH);

  if (!params_ok(N, D, FAULT_TH)) begin : g_bad_params
    $error("maj_vote_seq: illegal parameters N=%0d D=%0d FAULT_TH=%0d", N, D, FAULT_TH);
  end

  state_e                   r_state, w_state_nxt;
  logic                     w_pulse;
  logic [FW-1:0]            r_fill;
  logic [D-1:0]             r_win, w_win_nxt;
  logic [CW-1:0]            w_pc;
  logic [WW-1:0]            w_wpc;
  logic                     w_sp;
  logic [N-1:0][TW-1:0]     r_dis, w_dis_nxt;
  logic [N-1:0]             w_hit;
  logic                     r_ov, r_out, r_spatial;
  logic [CW-1:0]            r_count;
  logic [N-1:0]             r_fault;

  popcnt #(.W(N)) u_din_pc (.i_bits(din),       .o_count(w_pc));
  popcnt #(.W(D)) u_win_pc (.i_bits(w_win_nxt), .o_count(w_wpc));

  assign w_sp = (w_pc > NHALF);

  if (D == 1) begin : g_win1
    assign w_win_nxt = w_sp;
  end else begin : g_winn
    assign w_win_nxt = {r_win[D-2:0], w_sp};
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pulse     = 1'b0;
    if (clr) begin
      w_state_nxt = ST_FILL;
    end else if (in_valid) begin
      case (r_state)
        ST_FILL: if (r_fill == FW'(D-1)) begin
          w_state_nxt = ST_RUN;
          w_pulse     = 1'b1;
        end
        ST_RUN:  w_pulse = 1'b1;
        default: w_state_nxt = ST_FILL;
      endcase
    end
  end

  // A channel's counter uses the spatial result of the very sample it voted in.
  always_comb begin
    w_dis_nxt = '0;
    w_hit     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (din[i] != w_sp) w_dis_nxt[i] = (r_dis[i] == TH) ? TH : r_dis[i] + 1'b1;
      w_hit[i] = (w_dis_nxt[i] == TH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_FILL;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ov      <= 1'b0;
      r_out     <= 1'b0;
      r_spatial <= 1'b0;
      r_count   <= '0;
      r_fault   <= '0;
      r_fill    <= '0;
      r_win     <= '0;
      r_dis     <= '0;
    end else begin
      r_ov <= w_pulse;
      if (clr) begin
        r_out     <= 1'b0;
        r_spatial <= 1'b0;
        r_count   <= '0;
        r_fault   <= '0;
        r_fill    <= '0;
        r_win     <= '0;
        r_dis     <= '0;
      end else if (in_valid) begin
        r_spatial <= w_sp;
        r_count   <= w_pc;
        r_win     <= w_win_nxt;
        r_dis     <= w_dis_nxt;
        r_fault   <= r_fault | w_hit;
        if (r_fill != FW'(D)) r_fill <= r_fill + 1'b1;
        if (w_pulse) r_out <= (w_wpc > DHALF);
      end
    end
  end

  assign out_valid = r_ov;
  assign out       = r_out;
  assign spatial   = r_spatial;
  assign count     = r_count;
  assign fault     = r_fault;
  assign state     = r_state;

endmodule

// File: tb/tb_maj_vote_seq.sv
// Directed, table-driven bench for maj_vote_seq (N=3,D=5,TH=4) plus an
// N=5, D=1 instance for the single-sample window case.
module tb_maj_vote_seq;

  logic clk = 1'b0;
  logic rst_n;

  logic       clr, iv;
  logic [2:0] din;
  logic       ov, o, sp;
  logic [1:0] cnt, st;
  logic [2:0] flt;

  logic       clr2, iv2;
  logic [4:0] din2;
  logic       ov2, o2, sp2;
  logic [2:0] cnt2;
  logic [1:0] st2;
  logic [4:0] flt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  maj_vote_seq #(.N(3), .D(5), .FAULT_TH(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(iv), .din(din),
    .out_valid(ov), .out(o), .spatial(sp), .count(cnt), .fault(flt), .state(st)
  );

  maj_vote_seq #(.N(5), .D(1), .FAULT_TH(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr2), .in_valid(iv2), .din(din2),
    .out_valid(ov2), .out(o2), .spatial(sp2), .count(cnt2), .fault(flt2), .state(st2)
  );

  typedef struct {
    logic       iv;
    logic       clr;
    logic [2:0] din;
    logic       ov;
    logic       out;
    logic       sp;
    logic [1:0] cnt;
    logic [1:0] st;
    logic [2:0] flt;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mkv(logic v, logic c, logic [2:0] d, logic eov, logic eo,
                               logic esp, logic [1:0] ec, logic [1:0] est, logic [2:0] ef);
    vec_t r;
    r.iv = v; r.clr = c; r.din = d; r.ov = eov; r.out = eo;
    r.sp = esp; r.cnt = ec; r.st = est; r.flt = ef;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic eov, input logic eo, input logic esp,
                      input logic [1:0] ec, input logic [1:0] est, input logic [2:0] ef);
    chk({tag, " out_valid"}, ov, eov);
    chk({tag, " out"},       o,  eo);
    chk({tag, " spatial"},   sp, esp);
    chk({tag, " count"},     cnt, ec);
    chk({tag, " state"},     st, est);
    chk({tag, " fault"},     flt, ef);
  endtask

  initial begin
    rst_n = 1'b1;
    clr = 0; iv = 0; din = '0;
    clr2 = 0; iv2 = 0; din2 = '0;

    // spatial sequence din=0..7 through fill into run
    tv.push_back(mkv(1,0,3'd0, 0,0,0,2'd0,2'd1,3'b000));
    tv.push_back(mkv(1,0,3'd1, 0,0,0,2'd1,2'd1,3'b000));
    tv.push_back(mkv(1,0,3'd2, 0,0,0,2'd1,2'd1,3'b000));
    tv.push_back(mkv(1,0,3'd3, 0,0,1,2'd2,2'd1,3'b000));
    tv.push_back(mkv(1,0,3'd4, 1,0,0,2'd1,2'd2,3'b000));
    tv.push_back(mkv(1,0,3'd5, 1,0,1,2'd2,2'd2,3'b000));
    tv.push_back(mkv(1,0,3'd6, 1,1,1,2'd2,2'd2,3'b000));
    tv.push_back(mkv(1,0,3'd7, 1,1,1,2'd3,2'd2,3'b000));
    tv.push_back(mkv(0,0,3'd0, 0,1,1,2'd3,2'd2,3'b000));
    // clr with in_valid: sample dropped, back to FILL
    tv.push_back(mkv(1,1,3'd7, 0,0,0,2'd0,2'd1,3'b000));
    // channel 2 disagrees four times in a row
    tv.push_back(mkv(1,0,3'b011, 0,0,1,2'd2,2'd1,3'b000));
    tv.push_back(mkv(1,0,3'b011, 0,0,1,2'd2,2'd1,3'b000));
    tv.push_back(mkv(1,0,3'b011, 0,0,1,2'd2,2'd1,3'b000));
    tv.push_back(mkv(1,0,3'b011, 0,0,1,2'd2,2'd1,3'b100));
    tv.push_back(mkv(1,0,3'b111, 1,1,1,2'd3,2'd2,3'b100));
    tv.push_back(mkv(0,0,3'b000, 0,1,1,2'd3,2'd2,3'b100));
    // clr in RUN clears sticky fault
    tv.push_back(mkv(1,1,3'b111, 0,0,0,2'd0,2'd1,3'b000));
    // fill with gaps: idle cycles carry din that must be ignored
    tv.push_back(mkv(1,0,3'b111, 0,0,1,2'd3,2'd1,3'b000));
    tv.push_back(mkv(0,0,3'b000, 0,0,1,2'd3,2'd1,3'b000));
    tv.push_back(mkv(0,0,3'b000, 0,0,1,2'd3,2'd1,3'b000));
    tv.push_back(mkv(1,0,3'b000, 0,0,0,2'd0,2'd1,3'b000));
    tv.push_back(mkv(1,0,3'b111, 0,0,1,2'd3,2'd1,3'b000));
    tv.push_back(mkv(0,0,3'b000, 0,0,1,2'd3,2'd1,3'b000));
    tv.push_back(mkv(1,0,3'b110, 0,0,1,2'd2,2'd1,3'b000));
    tv.push_back(mkv(0,0,3'b000, 0,0,1,2'd2,2'd1,3'b000));
    tv.push_back(mkv(1,0,3'b011, 1,1,1,2'd2,2'd2,3'b000));
    tv.push_back(mkv(0,0,3'b000, 0,1,1,2'd2,2'd2,3'b000));

    #2 rst_n = 1'b0;
    #1;
    chk1("reset", 0, 0, 0, 2'd0, 2'd1, 3'b000);
    chk("reset2 out_valid", ov2, 1'b0);
    chk("reset2 state", st2, 2'd1);
    chk("reset2 count", cnt2, 3'd0);
    step;
    step;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      iv = tv[i].iv; clr = tv[i].clr; din = tv[i].din;
      step;
      chk1($sformatf("row%0d", i), tv[i].ov, tv[i].out, tv[i].sp, tv[i].cnt, tv[i].st, tv[i].flt);
    end

    // asynchronous reset between edges while in RUN, then a full refill
    iv = 1; clr = 0; din = 3'b111;
    step;
    chk1("pre_rst", 1, 1, 1, 2'd3, 2'd2, 3'b000);
    #2 rst_n = 1'b0;
    #1;
    chk1("async_rst", 0, 0, 0, 2'd0, 2'd1, 3'b000);
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step;
      chk($sformatf("refill%0d out_valid", k), ov, (k == 5) ? 1'b1 : 1'b0);
      chk($sformatf("refill%0d state", k), st, (k == 5) ? 2'd2 : 2'd1);
      chk($sformatf("refill%0d out", k), o, (k == 5) ? 1'b1 : 1'b0);
    end
    iv = 0;

    // N=5, D=1 instance: out follows spatial, RUN on first accept
    iv2 = 1; din2 = 5'b00111;
    step;
    chk("d1 out_valid", ov2, 1'b1);
    chk("d1 out", o2, 1'b1);
    chk("d1 count", cnt2, 3'd3);
    chk("d1 spatial", sp2, 1'b1);
    chk("d1 state", st2, 2'd2);
    iv2 = 0;
    step;
    chk("d1 idle out_valid", ov2, 1'b0);
    chk("d1 idle out", o2, 1'b1);
    iv2 = 1; din2 = 5'b00011;
    step;
    chk("d1 low out_valid", ov2, 1'b1);
    chk("d1 low out", o2, 1'b0);
    chk("d1 low count", cnt2, 3'd2);
    clr2 = 1;
    step;
    chk("d1 clr out_valid", ov2, 1'b0);
    chk("d1 clr state", st2, 2'd1);
    chk("d1 clr count", cnt2, 3'd0);
    clr2 = 0; iv2 = 0;
    step;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/maj_vote_seq.md
MAJ_VOTE_SEQ -- requirements
Module: maj_vote_seq

Interface
REQ-001 SHALL have parameter N, default 3: number of voter channels; odd, 3..15.
REQ-002 SHALL have parameter D, default 5: temporal window depth in accepted samples; odd, 1..31.
REQ-003 SHALL have parameter FAULT_TH, default 4: consecutive disagreements before a channel faults; 1..15.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port clr, input, 1: synchronous clear of the window, counters and faults.
REQ-007 SHALL have port in_valid, input, 1: din carries a sample this cycle.
REQ-008 SHALL have port din, input, N: one vote bit per channel.
REQ-009 SHALL have port out_valid, output, 1: out and spatial are valid; one-cycle pulse.
REQ-010 SHALL have port out, output, 1: temporal majority of the last D spatial results.
REQ-011 SHALL have port spatial, output, 1: registered spatial majority of the last accepted sample.
REQ-012 SHALL have port count, output, $clog2(N+1): registered popcount of the last accepted din.
REQ-013 SHALL have port fault, output, N: sticky per-channel fault flags.
REQ-014 SHALL have port state, output, 2: current state encoding, for debug.

Function
REQ-015 SHALL accept a sample when in_valid=1 and clr=0; no state, window or counter changes otherwise.
REQ-016 SHALL compute the spatial result of an accepted sample as 1 iff popcount(din) > N/2 (integer division).
REQ-017 SHALL register count and spatial one cycle after acceptance, and SHALL hold them until the next accepted sample.
REQ-018 SHALL shift each accepted spatial bit into a D-bit window; the newest bit enters at bit 0 and the oldest is discarded.
REQ-019 SHALL implement states FILL=2'd1 and RUN=2'd2, with FILL entered from reset or clr.
REQ-020 SHALL transition FILL->RUN on the acceptance that brings the fill count to D; the fill counter saturates at D.
REQ-021 SHALL pulse out_valid for exactly one cycle, in the cycle after each acceptance that occurs in RUN or that completes the fill.
REQ-022 SHALL drive out as 1 iff popcount(window including the new bit) > D/2; out holds its value between pulses.
REQ-023 SHALL, for D=1, make out equal spatial and enter RUN on the first accepted sample.
REQ-024 SHALL keep a per-channel disagreement counter: on each acceptance, increment if din[i] differs from that sample's spatial result, else reset to 0; the counter saturates at FAULT_TH.
REQ-025 SHALL set fault[i] in the cycle after counter i reaches FAULT_TH; fault[i] stays set until clr or reset.
REQ-026 SHALL give clr priority over in_valid when both are asserted: the sample is dropped, out_valid=0 next cycle, and state returns to FILL.
REQ-027 SHALL, on clr, empty the window, zero the fill counter, disagreement counters and fault, and zero out, spatial and count.

Reset
REQ-028 SHALL, on rst_n=0, immediately force state=FILL and out_valid=0, out=0, spatial=0, count=0, fault=0, and clear the window, fill counter and disagreement counters, independent of clk.
REQ-029 SHALL, after rst_n deasserts, accept a sample no earlier than the first rising edge of clk at which rst_n=1.

Structure
REQ-030 SHALL place state encodings (FILL, RUN) and the legal parameter bounds in a shared package maj_pkg.
REQ-031 SHALL implement popcount as one parameterised sub-module popcnt #(W), instantiated twice: once for din (W=N) and once for the window (W=D).
REQ-032 SHALL reject illegal parameters (even N or D, or out of range) at elaboration.

Verification
REQ-033 SHALL, with N=3 and D=5, feed din=0..7 with in_valid=1 on every cycle -> spatial sequence 0,0,0,1,0,1,1,1; the first out_valid follows the 5th sample; out=0,0,1,1 over the four pulses.
REQ-034 SHALL, with FAULT_TH=4, feed din=3'b011 four times -> fault=3'b100 one cycle after the 4th acceptance; fault stays 3'b100 after din=3'b111 is applied.
REQ-035 SHALL, in RUN, assert clr and in_valid together -> out_valid=0 next cycle, state=FILL, fault=0; the next D samples produce no pulse until the 5th.
REQ-036 SHALL, with in_valid toggling 1,0,0,1 over 5-sample fill traffic, advance the window only on the valid cycles; no spurious out_valid appears.
REQ-037 SHALL, on rst_n pulsed low mid-RUN between clock edges, clear all outputs before the next edge and require a full refill of D samples.
REQ-038 SHALL, with an N=5, D=1 instance and din=5'b00111, produce out_valid=1, out=1, count=3 one cycle after acceptance.
